// File: rtl/main_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : main_mem_arbiter
//  Description : Round-robin arbiter sharing one main-memory port between
//                ARB_NUM_CORES PE-array cores. Each grant runs one
//                fixed-length burst: ARB_FIXED_BURST_WRITE beats for writes,
//                ARB_FIXED_BURST_READ beats for reads.
//  Ports       : w_clock          - clock, rising edge
//                w_rst_n          - asynchronous active-low reset
//                w_req            - per-core burst request (level)
//                w_req_rw         - per-core direction, 1=write 0=read
//                w_req_addr       - per-core base address, core i at [i*AW +: AW]
//                w_main_mem_ready - memory accepts the presented beat
//                w_grant          - one-hot owner of the current burst
//                w_main_mem_en    - a beat is presented to memory
//                w_main_mem_rw    - direction of the current burst
//                w_main_mem_addr  - address of the current beat
//                w_beat_valid     - beat accepted this cycle (en & ready)
//                w_beat_last      - final beat of the burst is presented
//  Revision    : 1.0 - initial release
// ============================================================================
module main_mem_arbiter #(
  parameter int ARB_NUM_CORES         = 4,
  parameter int ARB_ADDR_WIDTH        = 16,
  parameter int ARB_FIXED_BURST_WRITE = 4,
  parameter int ARB_FIXED_BURST_READ  = 8,
  parameter int ARB_BURST_WIDTH       = 4
) (
  input  logic                                    w_clock,
  input  logic                                    w_rst_n,
  input  logic [ARB_NUM_CORES-1:0]                w_req,
  input  logic [ARB_NUM_CORES-1:0]                w_req_rw,
  input  logic [ARB_NUM_CORES*ARB_ADDR_WIDTH-1:0] w_req_addr,
  input  logic                                    w_main_mem_ready,
  output logic [ARB_NUM_CORES-1:0]                w_grant,
  output logic                                    w_main_mem_en,
  output logic                                    w_main_mem_rw,
  output logic [ARB_ADDR_WIDTH-1:0]               w_main_mem_addr,
  output logic                                    w_beat_valid,
  output logic                                    w_beat_last
);

  localparam int PTR_W = (ARB_NUM_CORES > 1) ? $clog2(ARB_NUM_CORES) : 1;
  localparam logic [ARB_BURST_WIDTH-1:0] LAST_WR = ARB_BURST_WIDTH'(ARB_FIXED_BURST_WRITE - 1);
  localparam logic [ARB_BURST_WIDTH-1:0] LAST_RD = ARB_BURST_WIDTH'(ARB_FIXED_BURST_READ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [ARB_NUM_CORES-1:0]    grant_q, grant_d;
  logic                        rw_q, rw_d;
  logic [ARB_ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ARB_BURST_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [PTR_W-1:0]            sel_q, sel_d;

  logic [ARB_ADDR_WIDTH-1:0]   req_addr_arr [ARB_NUM_CORES];
  logic [PTR_W-1:0]            rr_sel;
  logic [PTR_W-1:0]            rr_idx;
  logic                        rr_found;
  logic [ARB_BURST_WIDTH-1:0]  last_idx;
  logic                        in_burst;

  // Unpack the flat per-core address bus for indexed selection.
  for (genvar g = 0; g < ARB_NUM_CORES; g++) begin : g_addr_unpack
    assign req_addr_arr[g] = w_req_addr[g*ARB_ADDR_WIDTH +: ARB_ADDR_WIDTH];
  end

  // Round-robin search: first requester at ptr, ptr+1, ... (mod cores).
  always_comb begin
    rr_sel   = ptr_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < ARB_NUM_CORES; k++) begin
      rr_idx = PTR_W'((int'(ptr_q) + k) % ARB_NUM_CORES);
      if (!rr_found && w_req[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  assign in_burst = (state_q == ST_BURST);
  assign last_idx = rw_q ? LAST_WR : LAST_RD;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rw_d    = rw_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_d         = '0;
          grant_d[rr_sel] = 1'b1;
          rw_d            = w_req_rw[rr_sel];
          base_d          = req_addr_arr[rr_sel];
          cnt_d           = '0;
          sel_d           = rr_sel;
          state_d         = ST_BURST;
        end
      end
      ST_BURST: begin
        // Without ready everything holds; the burst cannot be abandoned.
        if (w_main_mem_ready) begin
          if (cnt_q == last_idx) begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
            // The owner just served moves to the back of the search order.
            ptr_d   = PTR_W'((int'(sel_q) + 1) % ARB_NUM_CORES);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rw_q    <= 1'b0;
      base_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rw_q    <= rw_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  // Outputs are gated by state so they fall to zero together with reset.
  assign w_grant         = grant_q;
  assign w_main_mem_en   = in_burst;
  assign w_main_mem_rw   = in_burst & rw_q;
  assign w_main_mem_addr = in_burst ? (base_q + ARB_ADDR_WIDTH'(cnt_q)) : '0;
  assign w_beat_last     = in_burst && (cnt_q == last_idx);
  assign w_beat_valid    = in_burst & w_main_mem_ready;

endmodule
`default_nettype wire

// File: tb/tb_main_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_mem_arbiter
//  Description : Directed self-checking bench for main_mem_arbiter. Expected
//                beats are queued when requests are raised and compared as
//                the arbiter accepts beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_mem_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 16;
  localparam int BWR = 4;
  localparam int BRD = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     req;
  logic [NC-1:0]     req_rw;
  logic [NC*AW-1:0]  req_addr;
  logic              ready;
  logic [NC-1:0]     grant;
  logic              en;
  logic              rw;
  logic [AW-1:0]     addr;
  logic              valid;
  logic              last;

  always #5 clk = ~clk;

  main_mem_arbiter #(
    .ARB_NUM_CORES        (NC),
    .ARB_ADDR_WIDTH       (AW),
    .ARB_FIXED_BURST_WRITE(BWR),
    .ARB_FIXED_BURST_READ (BRD),
    .ARB_BURST_WIDTH      (4)
  ) dut (
    .w_clock         (clk),
    .w_rst_n         (rst_n),
    .w_req           (req),
    .w_req_rw        (req_rw),
    .w_req_addr      (req_addr),
    .w_main_mem_ready(ready),
    .w_grant         (grant),
    .w_main_mem_en   (en),
    .w_main_mem_rw   (rw),
    .w_main_mem_addr (addr),
    .w_beat_valid    (valid),
    .w_beat_last     (last)
  );

  typedef struct packed {
    logic [NC-1:0] grant;
    logic          rw;
    logic          last;
    logic [AW-1:0] addr;
  } beat_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int core, input logic w, input logic [AW-1:0] base);
    req[core]                = 1'b1;
    req_rw[core]             = w;
    req_addr[core*AW +: AW]  = base;
  endtask

  task automatic push_burst(input int core, input logic w, input logic [AW-1:0] base);
    int    len;
    beat_t b;
    len = w ? BWR : BRD;
    for (int i = 0; i < len; i++) begin
      b.grant = NC'(1 << core);
      b.rw    = w;
      b.last  = (i == len - 1);
      b.addr  = base + AW'(i);
      q.push_back(b);
    end
  endtask

  // Walk the arbiter until every queued beat has been accepted, plus the
  // mandatory IDLE cycle after the final burst.
  task automatic drain(input logic [NC-1:0] drop, input int stall_beat,
                       input int stall_len, input int exp_cycles);
    int    budget;
    int    beat_idx;
    int    stall_rem;
    int    cyc;
    bit    gap;
    bit    expect_regrant;
    beat_t e;
    beat_t o;
    budget         = 3000;
    beat_idx       = 0;
    stall_rem      = stall_len;
    cyc            = 0;
    gap            = 1'b0;
    expect_regrant = 1'b0;
    while ((q.size() > 0 || gap) && budget > 0) begin
      @(negedge clk);
      budget--;
      ready = 1'b1;
      if (en && stall_rem > 0 && beat_idx == stall_beat) begin
        ready = 1'b0;
        stall_rem--;
      end
      #1;
      if (gap) begin
        chk("idle_gap_en", 32'(en), 32'd0);
        chk("idle_gap_grant", 32'(grant), 32'd0);
        gap            = 1'b0;
        expect_regrant = (q.size() > 0);
      end else begin
        if (expect_regrant) begin
          chk("regrant_en", 32'(en), 32'd1);
          expect_regrant = 1'b0;
        end
        if (en) begin
          cyc++;
          chk("grant_onehot", 32'($onehot(grant)), 32'd1);
          if ((grant & drop) != '0) req = req & ~grant;
          if (q.size() == 0) begin
            chk("unexpected_burst", 32'(en), 32'd0);
          end else if (valid) begin
            e = q.pop_front();
            o = {grant, rw, last, addr};
            chk("beat", 32'(o), 32'(e));
            beat_idx++;
            if (e.last) begin
              if (exp_cycles > 0) chk("burst_cycles", 32'(cyc), 32'(exp_cycles));
              cyc      = 0;
              beat_idx = 0;
              gap      = 1'b1;
            end
          end else begin
            chk("stall_valid", 32'(valid), 32'd0);
            chk("stall_addr", 32'(addr), 32'(q[0].addr));
            chk("stall_last", 32'(last), 32'(q[0].last));
          end
        end
      end
    end
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL drain_timeout: observed %0d beats pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_rw   = '0;
    req_addr = '0;
    ready    = 1'b1;

    // Reset state before any clock edge.
    #3;
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);

    // All four cores read from reset: served 0,1,2,3 with one IDLE between.
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NC; c++) begin
      set_req(c, 1'b0, AW'(16'h1000 * (c + 1)));
      push_burst(c, 1'b0, AW'(16'h1000 * (c + 1)));
    end
    drain(4'b1111, -1, 0, BRD);

    // Core 2 write burst at 0x0100.
    set_req(2, 1'b1, 16'h0100);
    push_burst(2, 1'b1, 16'h0100);
    drain(4'b0100, -1, 0, BWR);

    // Core 0 read wrapping past the top of the address space.
    set_req(0, 1'b0, 16'hFFFE);
    push_burst(0, 1'b0, 16'hFFFE);
    drain(4'b0001, -1, 0, BRD);

    // Core 0 holds req; core 3 joins mid-burst and must be served before
    // core 0 repeats.
    ready = 1'b0;
    set_req(0, 1'b0, 16'h0A00);
    @(negedge clk);
    #1;
    chk("hold_grant0", 32'(grant), 32'h1);
    set_req(3, 1'b1, 16'h0B00);
    push_burst(0, 1'b0, 16'h0A00);
    push_burst(3, 1'b1, 16'h0B00);
    push_burst(0, 1'b0, 16'h0A00);
    drain(4'b1000, -1, 0, 0);
    req = '0;

    // Core 1 read at 0x0040, third beat stalled for three cycles.
    set_req(1, 1'b0, 16'h0040);
    push_burst(1, 1'b0, 16'h0040);
    drain(4'b0010, 2, 3, BRD + 3);

    // Asynchronous reset mid-burst; afterwards the search restarts at core 0
    // so core 1 wins over core 3 even though the pointer had moved past it.
    set_req(3, 1'b0, 16'h0300);
    @(negedge clk);
    @(negedge clk);
    set_req(1, 1'b0, 16'h0500);
    @(posedge clk);
    #3;
    chk("pre_rst_en", 32'(en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", 32'(en), 32'd0);
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_addr", 32'(addr), 32'd0);
    chk("async_rst_last", 32'(last), 32'd0);
    @(negedge clk);
    #1;
    chk("held_rst_en", 32'(en), 32'd0);
    rst_n = 1'b1;
    push_burst(1, 1'b0, 16'h0500);
    push_burst(3, 1'b0, 16'h0300);
    drain(4'b1010, -1, 0, BRD);
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
